// File: rtl/data_bus_sram_resp.sv
// Data-bus responder backing a base-address window with on-chip word storage.
// Out-of-window accesses complete with err_o instead of stalling the bus.
module data_bus_sram_resp #(
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter logic [15:0] BASE_ADDR   = 16'h8000,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [15:0] addr_i,
   input  logic [15:0] data_i,
   output logic [15:0] data_o,
   output logic        ack_o,
   output logic        err_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
   localparam int unsigned AW = DEPTH_LOG2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   logic [15:0]   mem_q [DEPTH];
   state_t        state_q;
   logic [3:0]    cnt_q;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic          hit_q;
   logic [15:0]   wdata_q;
   logic          ack_q;
   logic          err_q;
   logic [15:0]   rdata_q;

   logic          in_hit;
   logic          fire_d;
   logic [AW-1:0] acc_addr_d;
   logic          acc_we_d;
   logic          acc_hit_d;
   logic [15:0]   acc_data_d;
   logic          wr_en;

   assign in_hit = (addr_i[15:AW] == BASE_ADDR[15:AW]);

   // With zero wait states the access completes straight from IDLE,
   // so the live bus values stand in for the not-yet-latched ones.
   always_comb begin
      acc_addr_d = addr_q;
      acc_we_d   = we_q;
      acc_hit_d  = hit_q;
      acc_data_d = wdata_q;
      fire_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            acc_addr_d = addr_i[AW-1:0];
            acc_we_d   = we_i;
            acc_hit_d  = in_hit;
            acc_data_d = data_i;
            fire_d     = stb_i && (WAIT_STATES == 0);
         end
         S_WAIT: fire_d = stb_i && (cnt_q == 4'd1);
         default: fire_d = 1'b0;
      endcase
   end

   assign wr_en = sys_rst & fire_d & acc_we_d & acc_hit_d;

   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem_q[acc_addr_d] <= acc_data_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         ack_q <= fire_d;
         err_q <= fire_d & ~acc_hit_d;
         if (fire_d && !acc_we_d) begin
            rdata_q <= acc_hit_d ? mem_q[acc_addr_d] : 16'h0000;
         end
         unique case (state_q)
            S_IDLE: begin
               if (stb_i) begin
                  addr_q  <= addr_i[AW-1:0];
                  we_q    <= we_i;
                  wdata_q <= data_i;
                  hit_q   <= in_hit;
                  cnt_q   <= WAIT_CNT;
                  state_q <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!stb_i) begin
                  state_q <= S_IDLE;
               end else if (cnt_q == 4'd1) begin
                  state_q <= S_ACK;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ack_o  = ack_q;
   assign err_o  = err_q;
   assign data_o = rdata_q;

endmodule

// File: tb/tb_data_bus_sram_resp.sv
// Bench for data_bus_sram_resp: two instances (2 and 0 wait states)
// checked every cycle against a transaction-level model.
module tb_data_bus_sram_resp;

   typedef struct {
      bit          we;
      bit          hit;
      logic [7:0]  a;
      logic [15:0] d;
   } ev_t;

   logic        clk;
   logic        rst_n;
   logic        stb  [2];
   logic        wen  [2];
   logic [15:0] addr [2];
   logic [15:0] din  [2];
   logic [15:0] dout [2];
   logic        ack  [2];
   logic        err  [2];

   int n_chk;
   int n_fail;
   int cyc;
   bit rst_hit;
   bit run;

   ev_t         evq [int];
   logic [15:0] mm  [2][256];
   bit          kn  [2][256];
   logic [15:0] ed  [2];
   bit          ek  [2];
   int          last_ack [2];
   int          prev_ack [2];
   bit          last_err [2];

   int  ckey;
   ev_t cev;
   bit  ea;
   bit  ee;

   data_bus_sram_resp #(
      .DEPTH_LOG2(8), .BASE_ADDR(16'h8000), .WAIT_STATES(2)
   ) u_dut (
      .sys_clk(clk), .sys_rst(rst_n),
      .stb_i(stb[0]), .we_i(wen[0]),
      .addr_i(addr[0]), .data_i(din[0]),
      .data_o(dout[0]), .ack_o(ack[0]), .err_o(err[0])
   );

   data_bus_sram_resp #(
      .DEPTH_LOG2(8), .BASE_ADDR(16'h8000), .WAIT_STATES(0)
   ) u_dut0 (
      .sys_clk(clk), .sys_rst(rst_n),
      .stb_i(stb[1]), .we_i(wen[1]),
      .addr_i(addr[1]), .data_i(din[1]),
      .data_o(dout[1]), .ack_o(ack[1]), .err_o(err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_hit <= !rst_n;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic int wait_of(int u);
      return (u == 0) ? 2 : 0;
   endfunction

   // Reference: an accepted request completes exactly W edges later
   always @(negedge clk) begin
      if (run) begin
         for (int u = 0; u < 2; u++) begin
            ckey = u * 1000000 + cyc;
            ea = 1'b0;
            ee = 1'b0;
            if (rst_hit) begin
               ed[u] = 16'h0000;
               ek[u] = 1'b1;
            end
            if (evq.exists(ckey)) begin
               cev = evq[ckey];
               ea = 1'b1;
               ee = !cev.hit;
               if (cev.we) begin
                  if (cev.hit) begin
                     mm[u][cev.a] = cev.d;
                     kn[u][cev.a] = 1'b1;
                  end
               end else if (cev.hit) begin
                  ed[u] = mm[u][cev.a];
                  ek[u] = kn[u][cev.a];
               end else begin
                  ed[u] = 16'h0000;
                  ek[u] = 1'b1;
               end
               evq.delete(ckey);
            end
            chk($sformatf("ack%0d", u), 32'(ack[u]), 32'(ea));
            chk($sformatf("err%0d", u), 32'(err[u]), 32'(ee));
            if (ek[u]) begin
               chk($sformatf("data%0d", u), 32'(dout[u]), 32'(ed[u]));
            end
            if (ack[u] === 1'b1) begin
               prev_ack[u] = last_ack[u];
               last_ack[u] = cyc;
               last_err[u] = err[u];
            end
         end
      end
   end

   // Called at a negedge; hold = edges stb stays high from acceptance.
   task automatic req(int u, logic [15:0] a, bit we,
                      logic [15:0] d, int hold, bit keep);
      int  w;
      int  e;
      ev_t ev;
      w = wait_of(u);
      stb[u]  = 1'b1;
      addr[u] = a;
      wen[u]  = we;
      din[u]  = d;
      e = cyc + 1;
      if (hold >= w + 1) begin
         ev.we  = we;
         ev.hit = ((a >> 8) == 16'h0080);
         ev.a   = a[7:0];
         ev.d   = d;
         evq[u * 1000000 + e + w] = ev;
      end
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         @(negedge clk);
         addr[u] = 16'($urandom);
         din[u]  = 16'($urandom);
         wen[u]  = 1'($urandom);
      end
      if (keep && hold >= w + 1) begin
         @(posedge clk);
         @(negedge clk);
      end else begin
         stb[u] = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic rand_run(int u, int n);
      int          w;
      int          r;
      int          hold;
      bit          keep;
      bit          pk;
      logic [15:0] a;
      w  = wait_of(u);
      pk = 1'b0;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) a = 16'h8000 | 16'($urandom_range(0, 15));
         else if (r < 8) a = 16'h80F0 | 16'($urandom_range(0, 15));
         else a = 16'($urandom);
         hold = w + 1;
         if (w > 0 && $urandom_range(0, 4) == 0) begin
            hold = $urandom_range(1, w);
         end
         keep = (hold == w + 1) && (i < n - 1) &&
                ($urandom_range(0, 2) == 0);
         if (!pk) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               @(negedge clk);
            end
         end
         req(u, a, 1'($urandom), 16'($urandom), hold, keep);
         pk = keep;
      end
   endtask

   int rise;
   int a0;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      run    = 1'b0;
      rst_n  = 1'b0;
      for (int u = 0; u < 2; u++) begin
         stb[u] = 1'b0; wen[u] = 1'b0;
         addr[u] = 16'h0; din[u] = 16'h0;
         ek[u] = 1'b0; ed[u] = 16'h0;
         last_ack[u] = -1; prev_ack[u] = -1; last_err[u] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b1;
      chk("rst_ack", 32'(ack[0]), 32'd0);
      chk("rst_data", 32'(dout[0]), 32'h0);

      req(0, 16'h8000, 1'b1, 16'h1357, 3, 1'b0);
      rise = cyc;
      req(0, 16'h8003, 1'b1, 16'hA5A5, 3, 1'b0);
      chk("wr_lat", 32'(last_ack[0] - rise), 32'd3);
      rise = cyc;
      req(0, 16'h8003, 1'b0, 16'h0000, 3, 1'b0);
      chk("rd_lat", 32'(last_ack[0] - rise), 32'd3);
      chk("rd_a5a5", 32'(dout[0]), 32'hA5A5);
      chk("rd_err0", 32'(last_err[0]), 32'd0);

      req(0, 16'h1234, 1'b0, 16'h0000, 3, 1'b0);
      chk("miss_err", 32'(last_err[0]), 32'd1);
      chk("miss_data", 32'(dout[0]), 32'h0);
      req(0, 16'h8003, 1'b0, 16'h0000, 3, 1'b0);
      chk("rd_again", 32'(dout[0]), 32'hA5A5);

      req(0, 16'h1000, 1'b1, 16'hFFFF, 3, 1'b0);
      chk("wmiss_err", 32'(last_err[0]), 32'd1);
      req(0, 16'h8000, 1'b0, 16'h0000, 3, 1'b0);
      chk("wmiss_keep", 32'(dout[0]), 32'h1357);

      req(0, 16'h8010, 1'b1, 16'h2222, 3, 1'b0);
      a0 = last_ack[0];
      req(0, 16'h8010, 1'b1, 16'h5555, 1, 1'b0);
      chk("abort_noack", 32'(last_ack[0]), 32'(a0));
      req(0, 16'h8010, 1'b0, 16'h0000, 3, 1'b0);
      chk("abort_nowr", 32'(dout[0]), 32'h2222);

      req(0, 16'h8020, 1'b1, 16'h0F0F, 3, 1'b0);
      a0 = last_ack[0];
      stb[0] = 1'b1; wen[0] = 1'b1;
      addr[0] = 16'h8020; din[0] = 16'hBEEF;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_ack", 32'(ack[0]), 32'd0);
      chk("mrst_err", 32'(err[0]), 32'd0);
      chk("mrst_data", 32'(dout[0]), 32'h0);
      stb[0] = 1'b0;
      rst_n  = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("mrst_noack", 32'(last_ack[0]), 32'(a0));
      rise = cyc;
      req(0, 16'h8020, 1'b0, 16'h0000, 3, 1'b0);
      chk("post_rst_lat", 32'(last_ack[0] - rise), 32'd3);
      chk("post_rst_rd", 32'(dout[0]), 32'h0F0F);

      req(1, 16'h8040, 1'b1, 16'h1111, 1, 1'b0);
      req(1, 16'h8041, 1'b1, 16'h2222, 1, 1'b0);
      rise = cyc;
      req(1, 16'h8040, 1'b0, 16'h0000, 1, 1'b1);
      chk("b2b_lat", 32'(last_ack[1] - rise), 32'd1);
      req(1, 16'h8041, 1'b0, 16'h0000, 1, 1'b0);
      chk("b2b_gap", 32'(last_ack[1] - prev_ack[1]), 32'd2);
      chk("b2b_data", 32'(dout[1]), 32'h2222);

      rand_run(0, 150);
      rand_run(1, 150);
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("evq_drained", 32'(evq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/data_bus_sram_resp.md
Name: data_bus_sram_resp

Overview:
Responder on the CPU data bus (stb/we/ack, 16-bit address and data), serving the end opposite to the CPU's data-port initiator. It decodes a base-address window and backs it with on-chip word storage, inserting a configurable number of wait states. Out-of-window accesses complete with an error flag instead of hanging the bus. It sits beside the memory controller as a fast scratchpad and bus-protocol checker.

Parameters:
DEPTH_LOG2, 8, log2 of storage depth in 16-bit words; window size is 2^DEPTH_LOG2 words.
BASE_ADDR, 16'h8000, window base (word address); bits [DEPTH_LOG2-1:0] ignored.
WAIT_STATES, 2, extra cycles between request accept and ack (0..15).

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst  input  1  synchronous reset, active-low
stb_i  input  1  request strobe from initiator, held until ack
we_i  input  1  1 = write, 0 = read; qualified by stb_i
addr_i  input  16  word address
data_i  input  16  write data
data_o  output  16  read data, valid in ack cycle
ack_o  output  1  single-cycle completion pulse
err_o  output  1  asserted with ack_o when address is out of window

Behaviour:
- Reset (sys_rst==0 at an edge): state IDLE, ack_o=0, err_o=0, data_o=16'h0000, wait counter=0. Storage contents not reset. Reset mid-transaction aborts it: no write, no ack.
- FSM states: IDLE, WAIT, ACK.
- IDLE: if stb_i==1, latch addr_i, we_i, data_i and hit = (addr_i[15:DEPTH_LOG2] == BASE_ADDR[15:DEPTH_LOG2]); load counter with WAIT_STATES; go WAIT if WAIT_STATES>0, else ACK.
- WAIT: counter decrements each cycle; when it reaches 1 and stb_i still 1, go ACK. If stb_i==0 in any WAIT cycle: abort, return to IDLE, no write, no ack.
- ACK: ack_o=1 for exactly this one cycle; err_o=~hit. Write hit: storage[latched addr low bits] <= latched data on the edge entering ACK. Read hit: data_o = storage word. Read miss: data_o = 16'h0000. Write miss: no storage change. The next state is always IDLE.
- Latency: request first seen at edge N -> ack_o high in cycle N+1+WAIT_STATES.
- stb_i is ignored in the ACK cycle. The initiator must drop stb_i in the cycle after ack. If stb_i is still 1 in the following IDLE cycle, it is a new request (back-to-back allowed; minimum 1 idle cycle between acks).
- Changes on addr_i, we_i, or data_i after accept are ignored; latched values are used.
- data_o holds its last ACK value outside ack cycles; it is updated only in ACK for reads. It is cleared to 0 on a read miss and unchanged on writes.
- err_o is 0 whenever ack_o is 0.
- Address low bits wrap naturally within the window. There is no byte enable; all accesses are full-word.

Test Plan:
- Write 16'hA5A5 to 16'h8003, then read 16'h8003 (WAIT_STATES=2) -> each ack_o occurs 3 cycles after stb_i rises; read data_o=16'hA5A5; err_o=0.
- Read 16'h1234 (out of window) -> ack_o with err_o=1, data_o=16'h0000; a following read of 16'h8003 still returns 16'hA5A5 (the miss write/read caused no corruption).
- Write to 16'h1000 (miss) with data 16'hFFFF, then read 16'h8000 -> err_o=1 on the write; the read returns the prior contents unchanged.
- Drop stb_i one cycle into WAIT during a write of 16'h5555 to 16'h8010 -> no ack; a later read of 16'h8010 returns the old value.
- Hold stb_i high across two back-to-back reads with WAIT_STATES=0 -> acks in cycles N+1 and N+3, each a single-cycle pulse, with the correct data.
- Assert sys_rst=0 during WAIT -> the next cycle shows ack_o=0, err_o=0, data_o=0, state IDLE; a request after reset release completes normally.
